// File: rtl/uart_tx_lec.sv
// uart_tx_lec
//   Byte-wide UART serialiser. A start request captures an 8-bit word, which
//   is then sent as a standard frame on one serial line: start bit 0, d0..d7
//   LSB first, then STOP_BITS stop bits at 1. Bit timing comes from a slower
//   bit-rate strobe (txck). txck is synchronised into the clk domain and
//   edge-detected here to make a one-clk tick.
//
// Parameters
//   SYNC_STAGES  flip-flop stages used to synchronise txck (>= 2)
//   STOP_BITS    stop bits per frame (1 or 2)
//
// Ports
//   clk     in   1  system clock, rising edge
//   rst     in   1  synchronous active-high reset; aborts any frame in progress
//   txck    in   1  bit-rate strobe; each rising edge is one bit period
//   tstart  in   1  level-sensitive start request, only accepted when idle
//   txpd    in   8  parallel data, captured when the request is accepted
//   txsd    out  1  serial data line, idle high, registered
//   bcnt    out  4  bit position of the frame in progress (0 when idle)
module uart_tx_lec #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txck,
  input  logic       tstart,
  input  logic [7:0] txpd,
  output logic       txsd,
  output logic [3:0] bcnt
);

  // bcnt value held during the last stop bit
  localparam logic [3:0] LAST_BCNT = 4'(10 + STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_tick;

  state_t     r_state;
  state_t     w_state_n;
  logic [7:0] r_shift;
  logic [7:0] w_shift_n;
  logic       r_txsd;
  logic       w_txsd_n;
  logic [3:0] r_bcnt;
  logic [3:0] w_bcnt_n;

  // Synchroniser, then a registered rising-edge pulse: with two stages the
  // tick is high after the third clk edge following a txck rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], txck};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_tick <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_txsd  <= 1'b1;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_txsd  <= w_txsd_n;
      r_bcnt  <= w_bcnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_txsd_n  = r_txsd;
    w_bcnt_n  = r_bcnt;
    case (r_state)
      S_IDLE: begin
        w_txsd_n = 1'b1;
        w_bcnt_n = '0;
        // A tick arriving in the accept cycle is deliberately ignored; the
        // start bit always waits for the following tick.
        if (tstart) begin
          w_shift_n = txpd;
          w_state_n = S_ARMED;
        end
      end
      S_ARMED: begin
        if (r_tick) begin
          w_state_n = S_START;
          w_txsd_n  = 1'b0;
          w_bcnt_n  = 4'd1;
        end
      end
      S_START: begin
        if (r_tick) begin
          w_state_n = S_DATA;
          w_txsd_n  = r_shift[0];
          w_shift_n = {1'b0, r_shift[7:1]};
          w_bcnt_n  = 4'd2;
        end
      end
      S_DATA: begin
        if (r_tick) begin
          if (r_bcnt == 4'd9) begin
            w_state_n = S_STOP;
            w_txsd_n  = 1'b1;
            w_bcnt_n  = 4'd10;
          end else begin
            w_txsd_n  = r_shift[0];
            w_shift_n = {1'b0, r_shift[7:1]};
            w_bcnt_n  = r_bcnt + 4'd1;
          end
        end
      end
      S_STOP: begin
        w_txsd_n = 1'b1;
        if (r_tick) begin
          if (r_bcnt == LAST_BCNT) begin
            w_state_n = S_IDLE;
            w_bcnt_n  = '0;
          end else begin
            w_bcnt_n = r_bcnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_txsd_n  = 1'b1;
        w_bcnt_n  = '0;
      end
    endcase
  end

  assign txsd = r_txsd;
  assign bcnt = r_bcnt;

endmodule

// File: tb/tb_uart_tx_lec.sv
module tb_uart_tx_lec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txck = 1'b0;
  logic       txck_en = 1'b1;
  logic       tstart = 1'b0;
  logic       tstart2 = 1'b0;
  logic [7:0] txpd = '0;
  logic [7:0] txpd2 = '0;
  logic       txsd, txsd2;
  logic [3:0] bcnt, bcnt2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  uart_tx_lec #(.SYNC_STAGES(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .txck(txck), .tstart(tstart),
    .txpd(txpd), .txsd(txsd), .bcnt(bcnt)
  );

  uart_tx_lec #(.SYNC_STAGES(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .txck(txck), .tstart(tstart2),
    .txpd(txpd2), .txsd(txsd2), .bcnt(bcnt2)
  );

  // clk period 10 ns, txck period 160 ns (16 clks per bit)
  initial forever #5 clk = ~clk;
  initial forever begin
    #80;
    if (txck_en) txck = ~txck;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] d;
    logic [9:0] line;   // line[j] = expected txsd during bit period j
  } vec_t;

  // Reference: frame bit j is start (0), d[j-1] for data, otherwise stop (1)
  function automatic logic model_line(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    return 1'b1;
  endfunction

  function automatic logic out_line(input int which);
    return (which == 1) ? txsd : txsd2;
  endfunction

  function automatic logic [3:0] out_cnt(input int which);
    return (which == 1) ? bcnt : bcnt2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait for the next txck rise and move to the middle of that bit period
  task automatic mid_tick();
    @(posedge txck);
    repeat (10) @(negedge clk);
  endtask

  // Request a frame just after a tick has been consumed, so the start bit
  // belongs to the next txck rise.
  task automatic start_req(input int which, input logic [7:0] d);
    @(posedge txck);
    repeat (6) @(negedge clk);
    if (which == 1) begin tstart = 1'b1; txpd = d; end
    else begin tstart2 = 1'b1; txpd2 = d; end
    @(negedge clk);
    if (which == 1) tstart = 1'b0;
    else tstart2 = 1'b0;
  endtask

  task automatic check_bits(input int which, input logic [7:0] d,
                            input int stops, input int from_j, input string tag);
    for (int j = from_j; j < 9 + stops; j++) begin
      mid_tick();
      chk({tag, " txsd"}, int'(out_line(which)), int'(model_line(d, j)));
      chk({tag, " bcnt"}, int'(out_cnt(which)), j + 1);
    end
    mid_tick();
    chk({tag, " idle txsd"}, int'(out_line(which)), 1);
    chk({tag, " idle bcnt"}, int'(out_cnt(which)), 0);
  endtask

  vec_t vec [4];
  int   found;
  logic [7:0] rd;
  logic       hold_sd;
  logic [3:0] hold_cnt;

  initial begin
    vec[0] = '{8'h3A, 10'b1001110100};
    vec[1] = '{8'hFF, 10'b1111111110};
    vec[2] = '{8'h8F, 10'b1100011110};
    vec[3] = '{8'h00, 10'b1000000000};

    // reset with txck running
    repeat (2) @(negedge clk);
    chk("rst txsd", int'(txsd), 1);
    chk("rst bcnt", int'(bcnt), 0);
    chk("rst txsd2", int'(txsd2), 1);
    chk("rst bcnt2", int'(bcnt2), 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mid_tick();
      chk("idle txsd", int'(txsd), 1);
      chk("idle bcnt", int'(bcnt), 0);
    end

    // table-driven frames
    for (int v = 0; v < 4; v++) begin
      start_req(1, vec[v].d);
      for (int j = 0; j < 10; j++) begin
        mid_tick();
        chk("vec txsd", int'(txsd), int'(vec[v].line[j]));
        chk("vec bcnt", int'(bcnt), j + 1);
      end
      mid_tick();
      chk("vec end txsd", int'(txsd), 1);
      chk("vec end bcnt", int'(bcnt), 0);
    end

    // data changed after accept must not affect the frame
    start_req(1, 8'hFF);
    txpd = 8'h8F;
    check_bits(1, 8'hFF, 1, 0, "capture");

    // tstart held: back-to-back frames, no restart mid-frame
    @(posedge txck);
    repeat (6) @(negedge clk);
    tstart = 1'b1;
    txpd = 8'h8F;
    for (int j = 0; j < 10; j++) begin
      mid_tick();
      chk("b2b1 txsd", int'(txsd), int'(model_line(8'h8F, j)));
      chk("b2b1 bcnt", int'(bcnt), j + 1);
    end
    found = 0;
    for (int k = 0; k < 3 && found == 0; k++) begin
      mid_tick();
      if (txsd == 1'b0) found = 1;
    end
    chk("b2b2 start", found, 1);
    chk("b2b2 start bcnt", int'(bcnt), 1);
    tstart = 1'b0;
    check_bits(1, 8'h8F, 1, 1, "b2b2");

    // txck frozen mid-frame: line holds
    start_req(1, 8'h3A);
    for (int j = 0; j < 4; j++) mid_tick();
    hold_sd = txsd;
    hold_cnt = bcnt;
    chk("pre-freeze bcnt", int'(bcnt), 4);
    txck_en = 1'b0;
    repeat (200) @(negedge clk);
    chk("freeze txsd", int'(txsd), int'(hold_sd));
    chk("freeze bcnt", int'(bcnt), int'(hold_cnt));
    txck_en = 1'b1;
    check_bits(1, 8'h3A, 1, 4, "thaw");

    // reset mid-frame
    start_req(1, 8'h55);
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      mid_tick();
      if (bcnt == 4'd5) found = 1;
    end
    chk("reach bcnt5", found, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort txsd", int'(txsd), 1);
    chk("abort bcnt", int'(bcnt), 0);
    mid_tick();
    chk("post-abort txsd", int'(txsd), 1);
    chk("post-abort bcnt", int'(bcnt), 0);
    start_req(1, 8'hC3);
    check_bits(1, 8'hC3, 1, 0, "post-abort");

    // two stop bits
    start_req(2, 8'h00);
    check_bits(2, 8'h00, 2, 0, "stop2");

    // randomized frames against the reference
    for (int r = 0; r < 6; r++) begin
      rd = 8'($urandom_range(0, 255));
      start_req(1, rd);
      check_bits(1, rd, 1, 0, "rand1");
    end
    for (int r = 0; r < 3; r++) begin
      rd = 8'($urandom_range(0, 255));
      start_req(2, rd);
      check_bits(2, rd, 2, 0, "rand2");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
